// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory arbiter: FSM states, access size codes
// and requester identifiers.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_LS = 2'd2,
        DRAIN   = 2'd3
    } arb_state_t;

    localparam logic [2:0] MEM_BYTE = 3'b000;
    localparam logic [2:0] MEM_HALF = 3'b001;
    localparam logic [2:0] MEM_WORD = 3'b010;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_LS = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin grant: on a tie the requester that did not win
// last time is chosen; a lone requester always wins.
module rr_arbiter2
    import mem_pkg::*;
(
    input  logic req_if,
    input  logic req_ls,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant,
    output logic grant_tie
);

    always_comb begin
        grant_valid = req_if | req_ls;
        grant_tie   = req_if & req_ls;
        if (grant_tie) begin
            grant = (last_grant == REQ_IF) ? REQ_LS : REQ_IF;
        end else begin
            grant = req_ls ? REQ_LS : REQ_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the byte-serial memory controller between instruction fetch and the
// load/store buffer; one transaction in flight, results returned as pulses.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no transaction; arbitrate and launch the next request
// BUSY_IF | fetch in flight, result goes to IF on mc_ready
// BUSY_LS | load/store in flight, result goes to LS on mc_ready
// DRAIN   | flushed fetch/load still owned by controller; wait, no pulse
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  clear,

    input  logic                  if_valid,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ready,
    output logic [DATA_WIDTH-1:0] if_data,

    input  logic                  ls_valid,
    input  logic                  ls_wr,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [2:0]            ls_type,
    input  logic [DATA_WIDTH-1:0] ls_data,
    output logic                  ls_ready,
    output logic [DATA_WIDTH-1:0] ls_result,

    output logic                  mc_valid,
    output logic                  mc_wr,
    output logic [ADDR_WIDTH-1:0] mc_addr,
    output logic [2:0]            mc_type,
    output logic [DATA_WIDTH-1:0] mc_data,
    input  logic                  mc_ready,
    input  logic [DATA_WIDTH-1:0] mc_result
);

    arb_state_t state;
    logic       last_grant;
    logic       req_if;
    logic       req_ls;
    logic       grant_valid;
    logic       grant;
    logic       grant_tie;

    // A flush blocks new fetches and loads for that cycle; stores are never speculative.
    assign req_if = if_valid & ~clear;
    assign req_ls = ls_valid & (ls_wr | ~clear);

    rr_arbiter2 u_rr (
        .req_if      (req_if),
        .req_ls      (req_ls),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant       (grant),
        .grant_tie   (grant_tie)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= REQ_LS;
            mc_valid   <= 1'b0;
            mc_wr      <= 1'b0;
            mc_addr    <= '0;
            mc_type    <= '0;
            mc_data    <= '0;
            if_ready   <= 1'b0;
            ls_ready   <= 1'b0;
            if_data    <= '0;
            ls_result  <= '0;
        end else if (rdy) begin
            if_ready <= 1'b0;
            ls_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        mc_valid <= 1'b1;
                        if (grant_tie) begin
                            last_grant <= grant;
                        end
                        if (grant == REQ_IF) begin
                            mc_wr   <= 1'b0;
                            mc_addr <= if_addr;
                            mc_type <= MEM_WORD;
                            mc_data <= '0;
                            state   <= BUSY_IF;
                        end else begin
                            mc_wr   <= ls_wr;
                            mc_addr <= ls_addr;
                            mc_type <= ls_type;
                            mc_data <= ls_data;
                            state   <= BUSY_LS;
                        end
                    end
                end
                BUSY_IF: begin
                    if (mc_ready) begin
                        mc_valid <= 1'b0;
                        state    <= IDLE;
                        if (!clear) begin
                            if_data  <= mc_result;
                            if_ready <= 1'b1;
                        end
                    end else if (clear) begin
                        state <= DRAIN;
                    end
                end
                BUSY_LS: begin
                    if (mc_ready) begin
                        mc_valid <= 1'b0;
                        state    <= IDLE;
                        if (mc_wr) begin
                            ls_result <= '0;
                            ls_ready  <= 1'b1;
                        end else if (!clear) begin
                            ls_result <= mc_result;
                            ls_ready  <= 1'b1;
                        end
                    end else if (clear && !mc_wr) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The controller cannot be aborted, so keep requesting until it finishes.
                    if (mc_ready) begin
                        mc_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected controller requests and requester
// responses are queued by the stimulus and checked by an independent monitor.
module tb_mem_arbiter;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy, clear;
    logic        if_valid;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_data;
    logic        ls_valid, ls_wr;
    logic [31:0] ls_addr;
    logic [2:0]  ls_type;
    logic [31:0] ls_data;
    logic        ls_ready;
    logic [31:0] ls_result;
    logic        mc_valid, mc_wr;
    logic [31:0] mc_addr;
    logic [2:0]  mc_type;
    logic [31:0] mc_data;
    logic        mc_ready;
    logic [31:0] mc_result;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  typ;
        logic [31:0] data;
    } req_t;

    typedef struct {
        logic        id;
        logic [31:0] data;
    } rsp_t;

    req_t        exp_req[$];
    rsp_t        exp_rsp[$];
    logic [31:0] res_q[$];
    req_t        hold;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   mc_lat  = 2;
    bit   mon_en  = 1'b0;
    logic mcv_prev = 1'b0;
    logic mcr_q = 1'b0;
    logic rdy_q = 1'b0;
    logic rst_q = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .clear     (clear),
        .if_valid  (if_valid),
        .if_addr   (if_addr),
        .if_ready  (if_ready),
        .if_data   (if_data),
        .ls_valid  (ls_valid),
        .ls_wr     (ls_wr),
        .ls_addr   (ls_addr),
        .ls_type   (ls_type),
        .ls_data   (ls_data),
        .ls_ready  (ls_ready),
        .ls_result (ls_result),
        .mc_valid  (mc_valid),
        .mc_wr     (mc_wr),
        .mc_addr   (mc_addr),
        .mc_type   (mc_type),
        .mc_data   (mc_data),
        .mc_ready  (mc_ready),
        .mc_result (mc_result)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_req(input logic [31:0] a, input logic w, input logic [2:0] t, input logic [31:0] d);
        req_t r;
        r.addr = a; r.wr = w; r.typ = t; r.data = d;
        exp_req.push_back(r);
    endtask

    task automatic push_rsp(input logic id, input logic [31:0] d);
        rsp_t r;
        r.id = id; r.data = d;
        exp_rsp.push_back(r);
    endtask

    task automatic wait_mcv(input int max);
        int i = 0;
        do begin
            tick(1);
            i++;
        end while (!mc_valid && i < max);
        if (!mc_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout_mc_valid: got mc_valid=0 after %0d cycles, expected 1", max);
        end
    endtask

    task automatic wait_rsp(input logic id, input int max);
        int i = 0;
        do begin
            tick(1);
            i++;
        end while (((id == REQ_IF) ? !if_ready : !ls_ready) && i < max);
        if ((id == REQ_IF) ? !if_ready : !ls_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout_rsp: got no ready for requester %0d in %0d cycles, expected a pulse", id, max);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mc_valid"}, 32'(mc_valid), 32'h0);
        chk({tag, "_mc_wr"}, 32'(mc_wr), 32'h0);
        chk({tag, "_mc_addr"}, mc_addr, 32'h0);
        chk({tag, "_mc_type"}, 32'(mc_type), 32'h0);
        chk({tag, "_mc_data"}, mc_data, 32'h0);
        chk({tag, "_if_ready"}, 32'(if_ready), 32'h0);
        chk({tag, "_ls_ready"}, 32'(ls_ready), 32'h0);
        chk({tag, "_if_data"}, if_data, 32'h0);
        chk({tag, "_ls_result"}, ls_result, 32'h0);
    endtask

    always @(posedge clk) begin
        mcr_q <= mc_ready;
        rdy_q <= rdy;
        rst_q <= rst;
    end

    // Memory controller model: answers after mc_lat cycles of an enabled request.
    initial begin : ctrl_model
        int cnt;
        cnt = 0;
        mc_ready = 1'b0;
        mc_result = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_q) begin
                mc_ready = 1'b0;
                cnt = 0;
            end else if (rdy_q) begin
                if (mc_ready) begin
                    mc_ready = 1'b0;
                    cnt = 0;
                end else if (mc_valid) begin
                    cnt++;
                    if (cnt >= mc_lat) begin
                        mc_ready = 1'b1;
                        mc_result = (res_q.size() > 0) ? res_q.pop_front() : 32'h0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en && rst) begin
            if (mc_valid && !mcv_prev) begin
                if (exp_req.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_grant: got request addr 0x%08h, expected no request", mc_addr);
                    hold <= '{mc_addr, mc_wr, mc_type, mc_data};
                end else begin
                    req_t e;
                    e = exp_req.pop_front();
                    chk("req_addr", mc_addr, e.addr);
                    chk("req_wr", 32'(mc_wr), 32'(e.wr));
                    chk("req_type", 32'(mc_type), 32'(e.typ));
                    chk("req_data", mc_data, e.data);
                    hold <= e;
                end
            end else if (mc_valid && mcv_prev) begin
                chk("req_stable_addr", mc_addr, hold.addr);
                chk("req_stable_ctrl", {28'h0, mc_wr, mc_type}, {28'h0, hold.wr, hold.typ});
                chk("req_stable_data", mc_data, hold.data);
            end
            if (!mc_valid && mcv_prev) begin
                chk("mc_valid_drop_after_mc_ready", 32'(mcr_q), 32'h1);
            end
            if (if_ready || ls_ready) begin
                chk("rsp_one_hot", 32'(if_ready & ls_ready), 32'h0);
                if (exp_rsp.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got if_ready=%b ls_ready=%b, expected no pulse", if_ready, ls_ready);
                end else begin
                    rsp_t e;
                    e = exp_rsp.pop_front();
                    chk("rsp_id", 32'(ls_ready), 32'(e.id));
                    chk("rsp_data", if_ready ? if_data : ls_result, e.data);
                    chk("rsp_mc_valid_low", 32'(mc_valid), 32'h0);
                    chk("rsp_latency", 32'(mcr_q), 32'h1);
                end
            end
        end
        mcv_prev <= mc_valid;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; rdy = 1'b1; clear = 1'b0;
        if_valid = 1'b0; if_addr = 32'h0;
        ls_valid = 1'b0; ls_wr = 1'b0; ls_addr = 32'h0; ls_type = 3'b000; ls_data = 32'h0;
        tick(3);
        chk_all_zero("reset");
        rst = 1'b1;
        mon_en = 1'b1;
        tick(2);

        // Single fetch
        mc_lat = 2;
        push_req(32'h0000_1000, 1'b0, MEM_WORD, 32'h0);
        push_rsp(REQ_IF, 32'hDEAD_BEEF);
        res_q.push_back(32'hDEAD_BEEF);
        if_addr = 32'h0000_1000;
        if_valid = 1'b1;
        tick(1);
        chk("fetch_grant_latency", 32'(mc_valid), 32'h1);
        wait_rsp(REQ_IF, 20);
        if_valid = 1'b0;
        tick(2);

        // Both requesters held: IF, LS, IF
        mc_lat = 1;
        if_addr = 32'h0000_2000;
        ls_wr = 1'b0; ls_addr = 32'h0000_3000; ls_type = MEM_WORD; ls_data = 32'h0;
        push_req(32'h0000_2000, 1'b0, MEM_WORD, 32'h0);
        push_req(32'h0000_3000, 1'b0, MEM_WORD, 32'h0);
        push_req(32'h0000_2000, 1'b0, MEM_WORD, 32'h0);
        push_rsp(REQ_IF, 32'h1111_1111);
        push_rsp(REQ_LS, 32'h2222_2222);
        push_rsp(REQ_IF, 32'h3333_3333);
        res_q.push_back(32'h1111_1111);
        res_q.push_back(32'h2222_2222);
        res_q.push_back(32'h3333_3333);
        if_valid = 1'b1;
        ls_valid = 1'b1;
        wait_rsp(REQ_IF, 20);
        wait_rsp(REQ_LS, 20);
        wait_rsp(REQ_IF, 20);
        if_valid = 1'b0;
        ls_valid = 1'b0;
        tick(2);

        // Store byte: result forced to zero even with nonzero controller data
        mc_lat = 3;
        ls_wr = 1'b1; ls_addr = 32'h0003_0000; ls_type = MEM_BYTE; ls_data = 32'h0000_0041;
        push_req(32'h0003_0000, 1'b1, MEM_BYTE, 32'h0000_0041);
        push_rsp(REQ_LS, 32'h0);
        res_q.push_back(32'hFFFF_FFFF);
        ls_valid = 1'b1;
        wait_rsp(REQ_LS, 20);
        ls_valid = 1'b0;
        tick(2);

        // clear in IDLE delays a fetch by one cycle
        mc_lat = 1;
        if_addr = 32'h0000_4000;
        push_req(32'h0000_4000, 1'b0, MEM_WORD, 32'h0);
        push_rsp(REQ_IF, 32'h4444_4444);
        res_q.push_back(32'h4444_4444);
        if_valid = 1'b1;
        clear = 1'b1;
        tick(1);
        chk("idle_clear_blocks_fetch", 32'(mc_valid), 32'h0);
        clear = 1'b0;
        tick(1);
        chk("fetch_after_clear", 32'(mc_valid), 32'h1);
        wait_rsp(REQ_IF, 20);
        if_valid = 1'b0;
        tick(2);

        // clear in IDLE does not block a store
        ls_wr = 1'b1; ls_addr = 32'h0000_4004; ls_type = MEM_HALF; ls_data = 32'h0000_BEEF;
        push_req(32'h0000_4004, 1'b1, MEM_HALF, 32'h0000_BEEF);
        push_rsp(REQ_LS, 32'h0);
        res_q.push_back(32'h0BAD_0BAD);
        ls_valid = 1'b1;
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk("idle_clear_allows_store", 32'(mc_valid), 32'h1);
        wait_rsp(REQ_LS, 20);
        ls_valid = 1'b0;
        tick(2);

        // clear during a fetch: drained, no pulse, if_data untouched
        mc_lat = 4;
        if_addr = 32'h0000_5000;
        push_req(32'h0000_5000, 1'b0, MEM_WORD, 32'h0);
        res_q.push_back(32'h1234_5678);
        if_valid = 1'b1;
        wait_mcv(10);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        if_valid = 1'b0;
        chk("drain_holds_mc_valid", 32'(mc_valid), 32'h1);
        tick(8);
        chk("drain_done_mc_valid", 32'(mc_valid), 32'h0);
        chk("drain_no_if_data", if_data, 32'h4444_4444);

        // clear during a store: ignored
        mc_lat = 3;
        ls_wr = 1'b1; ls_addr = 32'h0000_0040; ls_type = MEM_WORD; ls_data = 32'hCAFE_F00D;
        push_req(32'h0000_0040, 1'b1, MEM_WORD, 32'hCAFE_F00D);
        push_rsp(REQ_LS, 32'h0);
        res_q.push_back(32'h5555_AAAA);
        ls_valid = 1'b1;
        wait_mcv(10);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        wait_rsp(REQ_LS, 20);
        ls_valid = 1'b0;
        tick(2);

        // clear coinciding with mc_ready on a load: discarded
        mc_lat = 1;
        ls_wr = 1'b0; ls_addr = 32'h0000_0044; ls_type = MEM_HALF; ls_data = 32'h0;
        push_req(32'h0000_0044, 1'b0, MEM_HALF, 32'h0);
        res_q.push_back(32'h7777_7777);
        ls_valid = 1'b1;
        wait_mcv(10);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        ls_valid = 1'b0;
        chk("coincident_clear_mc_valid", 32'(mc_valid), 32'h0);
        tick(3);
        chk("coincident_clear_no_data", ls_result, 32'h0);

        // Reset while a load is in flight
        mc_lat = 50;
        ls_wr = 1'b0; ls_addr = 32'h0000_0060; ls_type = MEM_WORD; ls_data = 32'h0;
        push_req(32'h0000_0060, 1'b0, MEM_WORD, 32'h0);
        res_q.push_back(32'h9999_9999);
        ls_valid = 1'b1;
        wait_mcv(10);
        tick(1);
        rst = 1'b0;
        mon_en = 1'b0;
        tick(1);
        chk_all_zero("busy_ls_reset");
        ls_valid = 1'b0;
        rst = 1'b1;
        exp_rsp.delete();
        res_q.delete();
        tick(2);
        mon_en = 1'b1;
        tick(1);

        // rdy low for five cycles with mc_ready already pending
        mc_lat = 1;
        if_addr = 32'h0000_7000;
        push_req(32'h0000_7000, 1'b0, MEM_WORD, 32'h0);
        push_rsp(REQ_IF, 32'hABCD_0123);
        res_q.push_back(32'hABCD_0123);
        if_valid = 1'b1;
        wait_mcv(10);
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("freeze_mc_valid", 32'(mc_valid), 32'h1);
            chk("freeze_mc_addr", mc_addr, 32'h0000_7000);
            chk("freeze_if_ready", 32'(if_ready), 32'h0);
            chk("freeze_if_data", if_data, 32'h0);
        end
        rdy = 1'b1;
        wait_rsp(REQ_IF, 5);
        if_valid = 1'b0;
        tick(3);

        chk("exp_req_drained", 32'(exp_req.size()), 32'h0);
        chk("exp_rsp_drained", 32'(exp_rsp.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
